// File: rtl/rs_pkg.sv
// Shared reservation-station types: operand and entry layouts, CDB snoop helpers.
package rs_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int AGE_W  = 3;

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } operand_t;

    typedef struct packed {
        logic             busy;
        operand_t         op1;
        operand_t         op2;
        logic [TAG_W-1:0] tag;
        logic [RD_W-1:0]  rd;
        logic [AGE_W-1:0] age;
    } rs_entry_t;

    function automatic logic op_hit(
        input operand_t         op,
        input logic             cv,
        input logic [TAG_W-1:0] ct
    );
        return !op.rdy && cv && (op.tag == ct);
    endfunction

    function automatic operand_t op_snoop(
        input operand_t          op,
        input logic              cv,
        input logic [TAG_W-1:0]  ct,
        input logic [DATA_W-1:0] cd
    );
        operand_t r;
        r = op;
        if (op_hit(op, cv, ct)) begin
            r.rdy = 1'b1;
            r.val = cd;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Combinational picker: smallest age among candidate entries.
module rs_oldest_select
    import rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]       cand,
    input  logic [DEPTH*AGE_W-1:0] ages,
    output logic                   valid,
    output logic [IDX_W-1:0]       idx
);

    logic [AGE_W-1:0] best;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        best  = '1;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand[i] && (!valid || ages[i*AGE_W +: AGE_W] < best)) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
                best  = ages[i*AGE_W +: AGE_W];
            end
        end
    end

endmodule

// File: rtl/add_reservation_station.sv
// Add-class reservation station: CDB wakeup, oldest-ready issue to the adder.
// Define RS_WAKEUP_BYPASS_EN to let a CDB-woken entry issue in the broadcast cycle.
module add_reservation_station #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = rs_pkg::TAG_W,
    parameter int DATA_W = rs_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W+TAG_W:0]       in_rs1,
    input  logic [DATA_W+TAG_W:0]       in_rs2,
    input  logic [TAG_W-1:0]            in_tag,
    input  logic [4:0]                  in_rd,
    input  logic                        cdb_valid,
    input  logic [TAG_W-1:0]            cdb_tag,
    input  logic [DATA_W-1:0]           cdb_data,
    output logic                        fu_valid,
    input  logic                        fu_ready,
    output logic [DATA_W-1:0]           fu_op1,
    output logic [DATA_W-1:0]           fu_op2,
    output logic [TAG_W-1:0]            fu_tag,
    output logic [4:0]                  fu_rd,
    output logic [$clog2(DEPTH):0]      occupancy
);

    import rs_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    rs_entry_t [DEPTH-1:0]  ent, ent_n;
    logic [OCC_W-1:0]       occ, occ_n;
    logic [DEPTH-1:0]       cand, hit1, hit2;
    logic [DEPTH*AGE_W-1:0] ages;
    logic                   sel_valid;
    logic [IDX_W-1:0]       sel_idx, alloc_idx;
    logic [AGE_W-1:0]       sel_age, new_age;
    logic                   accept, issue;
    operand_t               new_op1, new_op2;

    assign in_ready  = occ < OCC_W'(DEPTH);
    assign occupancy = occ;
    assign accept    = in_valid && in_ready;
    assign issue     = sel_valid && fu_ready;
    assign fu_valid  = sel_valid;
    assign sel_age   = ent[sel_idx].age;
    assign new_age   = issue ? AGE_W'(occ - OCC_W'(1)) : AGE_W'(occ);

    // Incoming operands can be satisfied by the broadcast in their allocation cycle
    assign new_op1 = op_snoop(operand_t'(in_rs1), cdb_valid, cdb_tag, cdb_data);
    assign new_op2 = op_snoop(operand_t'(in_rs2), cdb_valid, cdb_tag, cdb_data);

    always_comb begin
        cand = '0;
        hit1 = '0;
        hit2 = '0;
        ages = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            hit1[i] = op_hit(ent[i].op1, cdb_valid, cdb_tag);
            hit2[i] = op_hit(ent[i].op2, cdb_valid, cdb_tag);
`endif
            cand[i] = ent[i].busy
                   && (ent[i].op1.rdy || hit1[i])
                   && (ent[i].op2.rdy || hit2[i]);
            ages[i*AGE_W +: AGE_W] = ent[i].age;
        end
    end

    rs_oldest_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .cand  (cand),
        .ages  (ages),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent[i].busy) alloc_idx = IDX_W'(i);
        end
    end

    always_comb begin
        fu_op1 = '0;
        fu_op2 = '0;
        fu_tag = '0;
        fu_rd  = '0;
        if (sel_valid) begin
            fu_op1 = hit1[sel_idx] ? cdb_data : ent[sel_idx].op1.val;
            fu_op2 = hit2[sel_idx] ? cdb_data : ent[sel_idx].op2.val;
            fu_tag = ent[sel_idx].tag;
            fu_rd  = ent[sel_idx].rd;
        end
    end

    always_comb begin
        ent_n = ent;
        occ_n = occ + OCC_W'(accept) - OCC_W'(issue);
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && sel_idx == IDX_W'(i)) begin
                ent_n[i] = '0;
            end else if (ent[i].busy) begin
                ent_n[i].op1 = op_snoop(ent[i].op1, cdb_valid, cdb_tag, cdb_data);
                ent_n[i].op2 = op_snoop(ent[i].op2, cdb_valid, cdb_tag, cdb_data);
                // Close the age gap left by the issued entry
                if (issue && ent[i].age > sel_age)
                    ent_n[i].age = ent[i].age - AGE_W'(1);
            end
            if (accept && alloc_idx == IDX_W'(i)) begin
                ent_n[i].busy = 1'b1;
                ent_n[i].op1  = new_op1;
                ent_n[i].op2  = new_op2;
                ent_n[i].tag  = in_tag;
                ent_n[i].rd   = in_rd;
                ent_n[i].age  = new_age;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent <= '0;
            occ <= '0;
        end else begin
            ent <= ent_n;
            occ <= occ_n;
        end
    end

endmodule

// File: tb/tb_add_reservation_station.sv
// Scoreboard bench for add_reservation_station (issue order and operand values).
module tb_add_reservation_station;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;
    localparam int OP_W   = DATA_W + TAG_W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_rs1;
    logic [OP_W-1:0]   in_rs2;
    logic [TAG_W-1:0]  in_tag;
    logic [4:0]        in_rd;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              fu_valid;
    logic              fu_ready;
    logic [DATA_W-1:0] fu_op1;
    logic [DATA_W-1:0] fu_op2;
    logic [TAG_W-1:0]  fu_tag;
    logic [4:0]        fu_rd;
    logic [2:0]        occupancy;

    typedef struct {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [TAG_W-1:0]  tag;
        logic [4:0]        rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    add_reservation_station #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_tag    (in_tag),
        .in_rd     (in_rd),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .fu_valid  (fu_valid),
        .fu_ready  (fu_ready),
        .fu_op1    (fu_op1),
        .fu_op2    (fu_op2),
        .fu_tag    (fu_tag),
        .fu_rd     (fu_rd),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [OP_W-1:0] opnd(input logic v,
                                             input logic [TAG_W-1:0] t,
                                             input logic [DATA_W-1:0] d);
        return {v, t, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [TAG_W-1:0] t, input logic [4:0] r);
        exp_t e;
        e.op1 = a;
        e.op2 = b;
        e.tag = t;
        e.rd  = r;
        sb.push_back(e);
    endtask

    task automatic dispatch(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                            input logic [TAG_W-1:0] t, input logic [4:0] r);
        in_valid = 1'b1;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = t;
        in_rd    = r;
        tick();
        in_valid = 1'b0;
    endtask

    // Every issue handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && !flush && fu_valid && fu_ready) begin
            if (sb.size() == 0) begin
                check("issue_unexpected", 64'(sb.size()), 64'(1));
            end else begin
                mon_e = sb.pop_front();
                check("issue_op1", 64'(fu_op1), 64'(mon_e.op1));
                check("issue_op2", 64'(fu_op2), 64'(mon_e.op2));
                check("issue_tag", 64'(fu_tag), 64'(mon_e.tag));
                check("issue_rd",  64'(fu_rd),  64'(mon_e.rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_tag    = '0;
        in_rd     = '0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        fu_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready),  64'(1));
        check("rst_fu_valid", 64'(fu_valid),  64'(0));
        check("rst_occ",      64'(occupancy), 64'(0));
        check("rst_fu_op1",   64'(fu_op1),    64'(0));
        check("rst_fu_tag",   64'(fu_tag),    64'(0));

        // Both operands ready at dispatch
        fu_ready = 1'b1;
        push_exp(5, 7, 2, 1);
        dispatch(opnd(1, 0, 5), opnd(1, 0, 7), 2, 1);
        check("t1_fu_valid", 64'(fu_valid), 64'(1));
        tick();
        check("t1_occ", 64'(occupancy), 64'(0));
        check("t1_fu_valid_after", 64'(fu_valid), 64'(0));

        // Wakeup from CDB two cycles after dispatch
        dispatch(opnd(0, 4, 0), opnd(1, 0, 3), 3, 2);
        check("t2_blocked", 64'(fu_valid), 64'(0));
        tick();
        cdb_valid = 1'b1;
        cdb_tag   = 4;
        cdb_data  = 10;
        push_exp(10, 3, 3, 2);
        #1;
`ifdef RS_WAKEUP_BYPASS_EN
        check("t2_bypass_valid", 64'(fu_valid), 64'(1));
        check("t2_bypass_op1",   64'(fu_op1),   64'(10));
        tick();
        cdb_valid = 1'b0;
`else
        check("t2_no_bypass", 64'(fu_valid), 64'(0));
        tick();
        cdb_valid = 1'b0;
        check("t2_woken_valid", 64'(fu_valid), 64'(1));
        check("t2_woken_op1",   64'(fu_op1),   64'(10));
        tick();
`endif
        check("t2_occ", 64'(occupancy), 64'(0));

        // Capture in the allocation cycle
        cdb_valid = 1'b1;
        cdb_tag   = 6;
        cdb_data  = 99;
        push_exp(1, 99, 5, 3);
        dispatch(opnd(1, 0, 1), opnd(0, 6, 0), 5, 3);
        cdb_valid = 1'b0;
        check("t3_valid", 64'(fu_valid), 64'(1));
        check("t3_op2",   64'(fu_op2),   64'(99));
        tick();
        check("t3_occ", 64'(occupancy), 64'(0));

        // Blocked A, ready B issues first, then A
        dispatch(opnd(0, 7, 0), opnd(1, 0, 2), 1, 6);
        push_exp(3, 4, 2, 7);
        dispatch(opnd(1, 0, 3), opnd(1, 0, 4), 2, 7);
        check("t5_b_first", 64'(fu_tag), 64'(2));
        tick();
        check("t5_occ_a", 64'(occupancy), 64'(1));
        cdb_valid = 1'b1;
        cdb_tag   = 7;
        cdb_data  = 50;
        push_exp(50, 2, 1, 6);
        tick();
        cdb_valid = 1'b0;
`ifndef RS_WAKEUP_BYPASS_EN
        tick();
`endif
        check("t5_occ", 64'(occupancy), 64'(0));

        // Older entry wakes while stalled and takes over selection
        fu_ready = 1'b0;
        dispatch(opnd(0, 5, 0), opnd(1, 0, 8), 4, 8);
        dispatch(opnd(1, 0, 11), opnd(1, 0, 12), 6, 9);
        check("t5b_young_sel", 64'(fu_tag), 64'(6));
        cdb_valid = 1'b1;
        cdb_tag   = 5;
        cdb_data  = 60;
        #1;
`ifdef RS_WAKEUP_BYPASS_EN
        check("t5b_old_sel", 64'(fu_tag), 64'(4));
        tick();
        cdb_valid = 1'b0;
`else
        check("t5b_not_yet", 64'(fu_tag), 64'(6));
        tick();
        cdb_valid = 1'b0;
        check("t5b_old_sel", 64'(fu_tag), 64'(4));
`endif
        push_exp(60, 8, 4, 8);
        push_exp(11, 12, 6, 9);
        fu_ready = 1'b1;
        tick();
        tick();
        fu_ready = 1'b0;
        check("t5b_occ", 64'(occupancy), 64'(0));

        // Fill to capacity, then issue while a dispatch is refused
        for (int i = 0; i < DEPTH; i++) begin
            push_exp(32'(i * 10 + 1), 32'(i * 10 + 2), TAG_W'(i), 5'(i + 4));
            dispatch(opnd(1, 0, 32'(i * 10 + 1)), opnd(1, 0, 32'(i * 10 + 2)),
                     TAG_W'(i), 5'(i + 4));
        end
        check("t4_full_ready", 64'(in_ready),  64'(0));
        check("t4_full_occ",   64'(occupancy), 64'(4));
        check("t4_oldest",     64'(fu_tag),    64'(0));
        in_valid = 1'b1;
        in_rs1   = opnd(1, 0, 77);
        in_rs2   = opnd(1, 0, 88);
        in_tag   = 7;
        in_rd    = 31;
        fu_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        fu_ready = 1'b0;
        check("t4_ready_after", 64'(in_ready),  64'(1));
        check("t4_occ_after",   64'(occupancy), 64'(3));
        check("t4_next_oldest", 64'(fu_tag),    64'(1));

        // Flush with live dispatch and issue handshakes
        check("t6_pre_valid", 64'(fu_valid), 64'(1));
        in_valid = 1'b1;
        fu_ready = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("t6_occ",      64'(occupancy), 64'(0));
        check("t6_fu_valid", 64'(fu_valid),  64'(0));
        check("t6_in_ready", 64'(in_ready),  64'(1));
        tick();
        tick();
        fu_ready = 1'b0;
        check("t6_still_empty", 64'(fu_valid), 64'(0));

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
